// File: rtl/vstreamout_sequencer.sv
// Stream-out sequencer: walks the enabled PE columns in ascending order and
// reads vec_len words from each column's register file over a valid/ready stream.
module vstreamout_sequencer #(
   parameter int NUM_COL = 4,
   parameter int ADDR_W  = 5,
   parameter int LEN_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [NUM_COL-1:0] col_mask,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [LEN_W-1:0]   vec_len,
   input  logic               m_ready,
   output logic               m_valid,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [NUM_COL-1:0] mux_sel,
   output logic               col_last,
   output logic               stream_last,
   output logic               busy,
   output logic               done
);

   // Stream handshake: a beat transfers on a cycle where m_valid && m_ready.
   // While m_valid && !m_ready, rd_addr, mux_sel, col_last and stream_last hold.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_COL-1:0] mask_q;
   logic [ADDR_W-1:0]  base_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   count;
   logic [NUM_COL-1:0] nxt_sel;
   logic [LEN_W-1:0]   count_inc;
   logic               xfer;

   function automatic logic [NUM_COL-1:0] lowest_bit(input logic [NUM_COL-1:0] v);
      return v & (~v + NUM_COL'(1));
   endfunction

   // Mask bits strictly above the one-hot position sel.
   function automatic logic [NUM_COL-1:0] higher_bits(input logic [NUM_COL-1:0] m,
                                                      input logic [NUM_COL-1:0] sel);
      return m & ~((sel << 1) - NUM_COL'(1));
   endfunction

   always_comb begin
      nxt_sel   = lowest_bit(higher_bits(mask_q, mux_sel));
      count_inc = count + LEN_W'(1);
      xfer      = m_valid & m_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         mask_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         count       <= '0;
         m_valid     <= 1'b0;
         rd_addr     <= '0;
         mux_sel     <= '0;
         col_last    <= 1'b0;
         stream_last <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mask_q <= col_mask;
                  base_q <= base_addr;
                  len_q  <= vec_len;
                  count  <= '0;
                  busy   <= 1'b1;
                  if (col_mask == '0 || vec_len == '0) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_STREAM;
                     m_valid     <= 1'b1;
                     mux_sel     <= lowest_bit(col_mask);
                     rd_addr     <= base_addr;
                     col_last    <= (vec_len == LEN_W'(1));
                     stream_last <= (vec_len == LEN_W'(1)) &&
                                    (higher_bits(col_mask, lowest_bit(col_mask)) == '0);
                  end
               end
            end
            S_STREAM: begin
               if (xfer) begin
                  if (col_last) begin
                     if (nxt_sel != '0) begin
                        mux_sel     <= nxt_sel;
                        rd_addr     <= base_q;
                        count       <= '0;
                        col_last    <= (len_q == LEN_W'(1));
                        stream_last <= (len_q == LEN_W'(1)) &&
                                       (higher_bits(mask_q, nxt_sel) == '0);
                     end else begin
                        state       <= S_DONE;
                        m_valid     <= 1'b0;
                        mux_sel     <= '0;
                        rd_addr     <= '0;
                        col_last    <= 1'b0;
                        stream_last <= 1'b0;
                        done        <= 1'b1;
                     end
                  end else begin
                     rd_addr     <= rd_addr + ADDR_W'(1);
                     count       <= count_inc;
                     col_last    <= (count_inc == len_q - LEN_W'(1));
                     stream_last <= (count_inc == len_q - LEN_W'(1)) && (nxt_sel == '0);
                  end
               end
            end
            S_DONE: begin
               // An empty request enters with done low and spends one extra cycle here.
               if (done) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vstreamout_sequencer.sv
// Directed bench for vstreamout_sequencer: walking columns, backpressure, empty
// requests, ignored start, address wrap and asynchronous reset mid-stream.
module tb_vstreamout_sequencer;
   localparam int NUM_COL = 4;
   localparam int ADDR_W  = 5;
   localparam int LEN_W   = 8;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [NUM_COL-1:0] col_mask;
   logic [ADDR_W-1:0]  base_addr;
   logic [LEN_W-1:0]   vec_len;
   logic               m_ready;
   logic               m_valid;
   logic [ADDR_W-1:0]  rd_addr;
   logic [NUM_COL-1:0] mux_sel;
   logic               col_last;
   logic               stream_last;
   logic               busy;
   logic               done;

   int tests;
   int fails;

   vstreamout_sequencer #(.NUM_COL(NUM_COL), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .col_mask(col_mask),
      .base_addr(base_addr), .vec_len(vec_len), .m_ready(m_ready),
      .m_valid(m_valid), .rd_addr(rd_addr), .mux_sel(mux_sel),
      .col_last(col_last), .stream_last(stream_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed beats and events gathered by collect().
   logic [NUM_COL-1:0] got_sel[$];
   logic [ADDR_W-1:0]  got_addr[$];
   logic               got_cl[$];
   logic               got_sl[$];
   int done_cnt, done_at, last_beat_at, valid_cycles, hold_err;
   logic [3:0] rdy_pat = 4'b1001;   // m_ready sequence 1,0,0,1 (bit 0 first)

   logic [NUM_COL-1:0] exp_sel9  [9] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd8, 4'd8, 4'd8};
   logic [ADDR_W-1:0]  exp_addr9 [9] = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
   logic               exp_cl9   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic               exp_sl9   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Called just after a posedge (+1); leaves the bench in the same phase.
   task automatic do_start(input logic [NUM_COL-1:0] m, input logic [ADDR_W-1:0] b,
                           input logic [LEN_W-1:0] l);
      col_mask = m; base_addr = b; vec_len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      col_mask = ~m; base_addr = ~b; vec_len = l + 8'd3;  // later changes must not matter
   endtask

   task automatic collect(input int ncyc, input bit bp, input int start_at);
      logic               prev_stall;
      logic [NUM_COL-1:0] prev_sel;
      logic [ADDR_W-1:0]  prev_addr;
      logic               prev_cl, prev_sl;
      got_sel.delete(); got_addr.delete(); got_cl.delete(); got_sl.delete();
      done_cnt = 0; done_at = -1; last_beat_at = -1; valid_cycles = 0; hold_err = 0;
      prev_stall = 1'b0; prev_sel = '0; prev_addr = '0; prev_cl = 1'b0; prev_sl = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         m_ready = bp ? rdy_pat[c % 4] : 1'b1;
         start   = (c == start_at);
         if (prev_stall && (!m_valid || mux_sel !== prev_sel || rd_addr !== prev_addr ||
                            col_last !== prev_cl || stream_last !== prev_sl))
            hold_err++;
         if (m_valid) valid_cycles++;
         if (m_valid && m_ready) begin
            got_sel.push_back(mux_sel); got_addr.push_back(rd_addr);
            got_cl.push_back(col_last); got_sl.push_back(stream_last);
            last_beat_at = c;
         end
         if (done) begin
            done_cnt++; done_at = c;
         end
         prev_stall = m_valid && !m_ready;
         prev_sel = mux_sel; prev_addr = rd_addr; prev_cl = col_last; prev_sl = stream_last;
         @(posedge clk); #1;
      end
      start = 1'b0; m_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
      col_mask = '0; base_addr = '0; vec_len = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({m_valid, rd_addr, mux_sel, col_last, stream_last, busy, done} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got valid=%b addr=%0d sel=%b cl=%b sl=%b busy=%b done=%b, need all 0",
                  m_valid, rd_addr, mux_sel, col_last, stream_last, busy, done);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({m_valid, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b, need 000", m_valid, busy, done);
      end
   endtask

   task automatic test_full_throughput();
      do_start(4'b1011, 5'd5, 8'd3);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL full_busy: got %b need 1", busy);
      end
      collect(20, 1'b0, -1);
      tests++;
      if (got_sel.size() != 9) begin
         fails++; $display("FAIL full_beat_count: got %0d need 9", got_sel.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            tests++;
            if (got_sel[i] !== exp_sel9[i] || got_addr[i] !== exp_addr9[i] ||
                got_cl[i] !== exp_cl9[i] || got_sl[i] !== exp_sl9[i]) begin
               fails++;
               $display("FAIL full_beat%0d: got sel=%b addr=%0d cl=%b sl=%b need sel=%b addr=%0d cl=%b sl=%b",
                        i, got_sel[i], got_addr[i], got_cl[i], got_sl[i],
                        exp_sel9[i], exp_addr9[i], exp_cl9[i], exp_sl9[i]);
            end
         end
      end
      tests++;
      if (valid_cycles != 9 || done_cnt != 1 || done_at != 9) begin
         fails++;
         $display("FAIL full_timing: got valid_cycles=%0d done_cnt=%0d done_at=%0d need 9/1/9",
                  valid_cycles, done_cnt, done_at);
      end
      tests++;
      if (busy !== 1'b0 || mux_sel !== '0) begin
         fails++; $display("FAIL full_idle_after: got busy=%b sel=%b need 0/0", busy, mux_sel);
      end
   endtask

   task automatic test_backpressure();
      do_start(4'b1011, 5'd5, 8'd3);
      collect(40, 1'b1, -1);
      tests++;
      if (got_sel.size() != 9) begin
         fails++; $display("FAIL bp_beat_count: got %0d need 9", got_sel.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            tests++;
            if (got_sel[i] !== exp_sel9[i] || got_addr[i] !== exp_addr9[i] ||
                got_cl[i] !== exp_cl9[i] || got_sl[i] !== exp_sl9[i]) begin
               fails++;
               $display("FAIL bp_beat%0d: got sel=%b addr=%0d cl=%b sl=%b need sel=%b addr=%0d cl=%b sl=%b",
                        i, got_sel[i], got_addr[i], got_cl[i], got_sl[i],
                        exp_sel9[i], exp_addr9[i], exp_cl9[i], exp_sl9[i]);
            end
         end
      end
      tests++;
      if (hold_err != 0) begin
         fails++; $display("FAIL bp_hold: got %0d unstable stall cycles need 0", hold_err);
      end
      tests++;
      if (done_cnt != 1 || done_at != last_beat_at + 1) begin
         fails++;
         $display("FAIL bp_done: got done_cnt=%0d done_at=%0d last_beat=%0d need 1 and last_beat+1",
                  done_cnt, done_at, last_beat_at);
      end
   endtask

   task automatic test_empty();
      do_start(4'b0000, 5'd2, 8'd4);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         fails++; $display("FAIL empty_mask_busy: got busy=%b done=%b need 1/0", busy, done);
      end
      collect(6, 1'b0, -1);
      tests++;
      if (valid_cycles != 0 || done_cnt != 1 || done_at != 1) begin
         fails++;
         $display("FAIL empty_mask: got valid_cycles=%0d done_cnt=%0d done_at=%0d need 0/1/1",
                  valid_cycles, done_cnt, done_at);
      end
      do_start(4'b1111, 5'd2, 8'd0);
      collect(6, 1'b0, -1);
      tests++;
      if (valid_cycles != 0 || done_cnt != 1 || done_at != 1) begin
         fails++;
         $display("FAIL empty_len: got valid_cycles=%0d done_cnt=%0d done_at=%0d need 0/1/1",
                  valid_cycles, done_cnt, done_at);
      end
   endtask

   task automatic test_start_while_busy();
      do_start(4'b0011, 5'd0, 8'd2);
      col_mask = 4'b1111; base_addr = 5'd20; vec_len = 8'd5;
      collect(25, 1'b0, 1);
      tests++;
      if (got_sel.size() != 4 || done_cnt != 1 || valid_cycles != 4) begin
         fails++;
         $display("FAIL busy_start: got beats=%0d done_cnt=%0d valid_cycles=%0d need 4/1/4",
                  got_sel.size(), done_cnt, valid_cycles);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      do_start(4'b1000, 5'd3, 8'd1);
      tests++;
      if (m_valid !== 1'b1 || mux_sel !== 4'b1000 || rd_addr !== 5'd3 ||
          col_last !== 1'b1 || stream_last !== 1'b1) begin
         fails++;
         $display("FAIL len1_beat: got v=%b sel=%b addr=%0d cl=%b sl=%b need 1/1000/3/1/1",
                  m_valid, mux_sel, rd_addr, col_last, stream_last);
      end
      m_ready = 1'b1;
      waited = 0;
      while (done !== 1'b1 && waited < 10) begin
         @(posedge clk); #1; waited++;
      end
      tests++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL b2b_done_timeout: got done=%b need 1 within 10 cycles", done);
      end
      @(posedge clk); #1;   // first cycle after done: start must be accepted here
      do_start(4'b0110, 5'd9, 8'd1);
      collect(8, 1'b0, -1);
      tests++;
      if (got_sel.size() != 2) begin
         fails++; $display("FAIL b2b_beat_count: got %0d need 2", got_sel.size());
      end else begin
         tests++;
         if (got_sel[0] !== 4'b0010 || got_addr[0] !== 5'd9 || got_cl[0] !== 1'b1 || got_sl[0] !== 1'b0 ||
             got_sel[1] !== 4'b0100 || got_addr[1] !== 5'd9 || got_cl[1] !== 1'b1 || got_sl[1] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_beats: got (%b,%0d,%b,%b)(%b,%0d,%b,%b) need (0010,9,1,0)(0100,9,1,1)",
                     got_sel[0], got_addr[0], got_cl[0], got_sl[0],
                     got_sel[1], got_addr[1], got_cl[1], got_sl[1]);
         end
      end
   endtask

   task automatic test_addr_wrap();
      logic [ADDR_W-1:0] exp_a [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
      do_start(4'b0100, 5'd30, 8'd4);
      collect(10, 1'b0, -1);
      tests++;
      if (got_sel.size() != 4) begin
         fails++; $display("FAIL wrap_beat_count: got %0d need 4", got_sel.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (got_addr[i] !== exp_a[i] || got_sel[i] !== 4'b0100 ||
                got_sl[i] !== (i == 3) || got_cl[i] !== (i == 3)) begin
               fails++;
               $display("FAIL wrap_beat%0d: got addr=%0d sel=%b cl=%b sl=%b need addr=%0d sel=0100 cl=sl=%0d",
                        i, got_addr[i], got_sel[i], got_cl[i], got_sl[i], exp_a[i], (i == 3));
            end
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      do_start(4'b1011, 5'd5, 8'd3);
      m_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;   // two beats transferred, third on the bus
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (m_valid !== 1'b0 || mux_sel !== '0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: got valid=%b sel=%b busy=%b need 0/0/0", m_valid, mux_sel, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      collect(6, 1'b0, -1);
      tests++;
      if (done_cnt != 0 || valid_cycles != 0) begin
         fails++;
         $display("FAIL reset_no_done: got done_cnt=%0d valid_cycles=%0d need 0/0", done_cnt, valid_cycles);
      end
      do_start(4'b0001, 5'd0, 8'd2);
      collect(8, 1'b0, -1);
      tests++;
      if (got_sel.size() != 2 || done_cnt != 1) begin
         fails++;
         $display("FAIL restart_count: got beats=%0d done_cnt=%0d need 2/1", got_sel.size(), done_cnt);
      end else begin
         tests++;
         if (got_addr[0] !== 5'd0 || got_addr[1] !== 5'd1 ||
             got_sel[0] !== 4'b0001 || got_sel[1] !== 4'b0001 || got_sl[1] !== 1'b1) begin
            fails++;
            $display("FAIL restart_beats: got (%b,%0d)(%b,%0d) sl=%b need (0001,0)(0001,1) sl=1",
                     got_sel[0], got_addr[0], got_sel[1], got_addr[1], got_sl[1]);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_full_throughput();
      test_backpressure();
      test_empty();
      test_start_while_busy();
      test_back_to_back();
      test_addr_wrap();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vstreamout_sequencer.md
Name: vstreamout_sequencer

Overview:
- Parametrised stream-out controller for the CGRA column array.
- On a start pulse, visits every enabled column in ascending index order and streams `vec_len` words from each column's register file.
- Drives the one-hot column mux select and the RF read address.
- Exposes a valid/ready handshake toward the output stream, with per-column and per-stream last flags and a completion pulse.

Parameters:
- NUM_COL, 4, number of PE columns (≥1).
- ADDR_W, 5, RF read-address width.
- LEN_W, 8, width of the vector-length field.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  1-cycle request; sampled only in IDLE.
- col_mask  in  NUM_COL  columns to stream; sampled with start.
- base_addr  in  ADDR_W  first RF address per column; sampled with start.
- vec_len  in  LEN_W  words per column; sampled with start.
- m_ready  in  1  downstream ready.
- m_valid  out  1  current beat valid.
- rd_addr  out  ADDR_W  RF address of current beat.
- mux_sel  out  NUM_COL  one-hot column select; zero when not streaming.
- col_last  out  1  current beat is last of its column.
- stream_last  out  1  current beat is last of whole request.
- busy  out  1  high from the cycle after start acceptance through DONE.
- done  out  1  1-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched mask/len/base cleared.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, STREAM, DONE.
- IDLE, start=1:
  - Latch col_mask, base_addr, vec_len.
  - If mask==0 or vec_len==0: go to DONE.
  - Otherwise go to STREAM with mux_sel = lowest set mask bit, rd_addr = base_addr, beat count = 0, m_valid = 1.
  - First beat is visible the cycle after start (latency 1).
- IDLE, start=0: no action.
- STREAM handshake:
  - A beat transfers when m_valid && m_ready.
  - Without a transfer, rd_addr, mux_sel, col_last and stream_last hold; m_valid stays 1.
- STREAM, transfer on a non-final beat of a column: rd_addr+1 modulo 2^ADDR_W (wraps, no error); count+1.
- col_last = 1 when count == vec_len-1.
- STREAM, transfer with col_last=1:
  - If a higher-index mask bit remains: mux_sel moves to the next set bit (skipping cleared bits, zero bubble cycles); rd_addr reloads base_addr; count = 0.
  - Otherwise: go to DONE; m_valid = 0; mux_sel = 0.
- stream_last = col_last && no higher enabled column remains.
- DONE: done=1 for exactly one cycle, busy=1 in DONE, then IDLE. An empty request also produces exactly one done pulse, 2 cycles after start.
- start while busy (STREAM or DONE) is ignored, not queued. start is first accepted in the cycle after done.
- Input changes on col_mask, base_addr, vec_len after acceptance have no effect.
- vec_len==1: every beat has col_last=1.
- NUM_COL==1: mux_sel constant 1 while streaming.
- rst_n asserted mid-operation: immediately returns to reset values (m_valid and mux_sel drop asynchronously); no done pulse. After deassertion the block waits in IDLE for a new start.
- Total transfers per request = popcount(mask) * vec_len, independent of backpressure.

Test Plan:
- Full throughput, walking columns. Setup: NUM_COL=4, mask=4'b1011, base=5, len=3, m_ready=1. Required response:
  - Beats (col, addr): (0,5)(0,6)(0,7)(1,5)(1,6)(1,7)(3,5)(3,6)(3,7).
  - col_last on beats 3, 6, 9; stream_last only on beat 9.
  - done 1 cycle after beat 9; 9 contiguous valid cycles.
- Backpressure. Same request with m_ready toggling 1,0,0,1,… Required response: rd_addr and mux_sel stable while m_valid && !m_ready; same 9-beat sequence; done only after the 9th transfer.
- Empty request and start while busy.
  - mask=0, len=4: no m_valid, done pulses 2 cycles after start.
  - len=0, mask=4'hF: same result as mask=0.
  - start pulsed during STREAM: ignored, exactly one done.
- Address wrap. ADDR_W=5, base=30, len=4, mask=4'b0100. Required response: addrs 30, 31, 0, 1 on mux_sel=4'b0100; stream_last on addr 1.
- Reset mid-stream. Drive rst_n low after 2 beats. Required response:
  - m_valid, mux_sel and busy go to 0 without waiting for clk; no done.
  - A new start (mask=4'b0001, base=0, len=2) then yields beats 0, 1 and one done.
